// File: rtl/mem_arbiter.sv
// Round-robin arbiter that lets two cache requesters share one memory port.
// It sends a one-cycle issue pulse, then routes response beats to the owner until the last one.
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req_valid,
  input  logic [ADDR_W-1:0] r0_req_addr,
  input  logic [DATA_W-1:0] r0_req_data,
  input  logic [3:0]        r0_req_mask,
  output logic              r0_resp_valid,
  output logic              r0_resp_last,
  input  logic              r1_req_valid,
  input  logic [ADDR_W-1:0] r1_req_addr,
  input  logic [DATA_W-1:0] r1_req_data,
  input  logic [3:0]        r1_req_mask,
  output logic              r1_resp_valid,
  output logic              r1_resp_last,
  output logic [DATA_W-1:0] resp_data,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  output logic [3:0]        mem_req_mask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              busy
);
  localparam int CNT_W = $clog2(BURST_LEN);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d, prio_q, prio_d, is_wr_q, is_wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        mask_q, mask_d;
  logic              gnt, beat, last;

  logic [1:0][ADDR_W-1:0] rq_addr;
  logic [1:0][DATA_W-1:0] rq_data;
  logic [1:0][3:0]        rq_mask;

  assign rq_addr = {r1_req_addr, r0_req_addr};
  assign rq_data = {r1_req_data, r0_req_data};
  assign rq_mask = {r1_req_mask, r0_req_mask};

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    is_wr_d = is_wr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    // Lone requester wins outright; prio only breaks a tie.
    gnt  = (r0_req_valid && r1_req_valid) ? prio_q : r1_req_valid;
    beat = (state_q == WAIT) && mem_resp_valid;
    last = beat && (is_wr_q || cnt_q == CNT_W'(BURST_LEN - 1));
    case (state_q)
      IDLE: if (r0_req_valid || r1_req_valid) begin
        owner_d = gnt;
        addr_d  = rq_addr[gnt];
        data_d  = rq_data[gnt];
        mask_d  = rq_mask[gnt];
        is_wr_d = |rq_mask[gnt];
        cnt_d   = '0;
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (beat) begin
        if (last) begin
          state_d = IDLE;
          prio_d  = ~owner_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      is_wr_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      is_wr_q <= is_wr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

  assign mem_req_valid = (state_q == ISSUE);
  assign mem_req_addr  = addr_q;
  assign mem_req_data  = data_q;
  assign mem_req_mask  = mask_q;
  assign busy          = (state_q != IDLE);
  assign resp_data     = mem_resp_data;
  assign r0_resp_valid = beat && !owner_q;
  assign r1_resp_valid = beat &&  owner_q;
  assign r0_resp_last  = last && !owner_q;
  assign r1_resp_last  = last &&  owner_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level model predicts every output each cycle.
// Directed scenarios pin that model with literal expectations, and a random phase follows.
module tb_mem_arbiter;
  localparam int AW = 32, DW = 32, BL = 16;

  logic clk = 1'b0, rst;
  logic r0_req_valid, r1_req_valid;
  logic [AW-1:0] r0_req_addr, r1_req_addr;
  logic [DW-1:0] r0_req_data, r1_req_data;
  logic [3:0] r0_req_mask, r1_req_mask;
  logic r0_resp_valid, r0_resp_last, r1_resp_valid, r1_resp_last;
  logic [DW-1:0] resp_data, mem_req_data, mem_resp_data;
  logic [AW-1:0] mem_req_addr;
  logic [3:0] mem_req_mask;
  logic mem_req_valid, mem_resp_valid, busy;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .r0_req_valid(r0_req_valid), .r0_req_addr(r0_req_addr), .r0_req_data(r0_req_data),
    .r0_req_mask(r0_req_mask), .r0_resp_valid(r0_resp_valid), .r0_resp_last(r0_resp_last),
    .r1_req_valid(r1_req_valid), .r1_req_addr(r1_req_addr), .r1_req_data(r1_req_data),
    .r1_req_mask(r1_req_mask), .r1_resp_valid(r1_resp_valid), .r1_resp_last(r1_resp_last),
    .resp_data(resp_data), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an issue flag plus the number of beats still owed.
  logic m_issuing = 0, m_owner = 0, m_prio = 0;
  int m_left = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [3:0] m_mask = '0;
  logic m_gnt;
  logic [3:0] m_gmask;
  assign m_gnt   = (r0_req_valid && r1_req_valid) ? m_prio : r1_req_valid;
  assign m_gmask = m_gnt ? r1_req_mask : r0_req_mask;

  always @(posedge clk) begin
    if (rst) begin
      m_issuing <= 0; m_left <= 0; m_owner <= 0; m_prio <= 0;
      m_addr <= '0; m_data <= '0; m_mask <= '0;
    end else if (m_issuing) begin
      m_issuing <= 0;
    end else if (m_left > 0) begin
      if (mem_resp_valid) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_prio <= ~m_owner;
      end
    end else if (r0_req_valid || r1_req_valid) begin
      m_owner   <= m_gnt;
      m_addr    <= m_gnt ? r1_req_addr : r0_req_addr;
      m_data    <= m_gnt ? r1_req_data : r0_req_data;
      m_mask    <= m_gmask;
      m_left    <= (m_gmask != 0) ? 1 : BL;
      m_issuing <= 1;
    end
  end

  // Compare process plus event bookkeeping used by the literal checks.
  logic chk_en = 0;
  int cyc = 0, last_cyc = -1;
  int r0_beats = 0, r1_beats = 0, r0_lasts = 0, r1_lasts = 0, last_beat_no = 0;
  int issues = 0;
  logic [AW-1:0] iss_addr;
  logic [DW-1:0] iss_data;
  logic [3:0] iss_mask;
  logic [DW-1:0] dq[$];
  int order[$];

  always @(negedge clk) begin
    logic e_beat;
    cyc++;
    if (chk_en) begin
      e_beat = !m_issuing && (m_left > 0) && mem_resp_valid;
      chk("mem_req_valid", mem_req_valid, m_issuing);
      chk("mem_req_addr", mem_req_addr, m_addr);
      chk("mem_req_data", mem_req_data, m_data);
      chk("mem_req_mask", mem_req_mask, m_mask);
      chk("busy", busy, m_issuing || (m_left > 0));
      chk("r0_resp_valid", r0_resp_valid, e_beat && !m_owner);
      chk("r1_resp_valid", r1_resp_valid, e_beat && m_owner);
      chk("r0_resp_last", r0_resp_last, e_beat && !m_owner && m_left == 1);
      chk("r1_resp_last", r1_resp_last, e_beat && m_owner && m_left == 1);
      chk("resp_data", resp_data, mem_resp_data);
      if (mem_req_valid) begin
        issues++;
        iss_addr = mem_req_addr; iss_data = mem_req_data; iss_mask = mem_req_mask;
        if (last_cyc >= 0) chk("issue_gap_ge2", (cyc - last_cyc) >= 2, 1);
      end
      if (r0_resp_valid) begin r0_beats++; dq.push_back(resp_data); end
      if (r1_resp_valid) begin r1_beats++; dq.push_back(resp_data); end
      if (r0_resp_last) begin r0_lasts++; order.push_back(0); last_beat_no = r0_beats; last_cyc = cyc; end
      if (r1_resp_last) begin r1_lasts++; order.push_back(1); last_beat_no = r1_beats; last_cyc = cyc; end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    r0_req_valid = 0; r1_req_valid = 0;
    r0_req_addr = '0; r1_req_addr = '0; r0_req_data = '0; r1_req_data = '0;
    r0_req_mask = '0; r1_req_mask = '0;
    mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  // One requester runs a transaction; memory strobes every cycle except a
  // 3-cycle hole after beat gap_at. Beat k carries 0xA000+k.
  task automatic do_txn(input logic who, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] m, input int gap_at);
    int b0, l0, gap, k;
    b0 = r0_beats + r1_beats; l0 = r0_lasts + r1_lasts; gap = 0;
    if (who) begin r1_req_valid = 1; r1_req_addr = a; r1_req_data = d; r1_req_mask = m; end
    else     begin r0_req_valid = 1; r0_req_addr = a; r0_req_data = d; r0_req_mask = m; end
    for (k = 0; k < 200; k++) begin
      if (r0_lasts + r1_lasts != l0) break;
      mem_resp_valid = 1;
      if ((r0_beats + r1_beats - b0) == gap_at && gap < 3) begin mem_resp_valid = 0; gap++; end
      mem_resp_data = 32'hA000 + DW'(r0_beats + r1_beats - b0);
      step();
    end
    if (k == 200) chk("txn_timeout", 0, 1);
    r0_req_valid = 0; r1_req_valid = 0; mem_resp_valid = 0;
  endtask

  initial begin
    int b0, b1, n, k;
    logic done0, done1;
    int s0, s1;
    idle_inputs();
    rst = 1;
    step(); step();
    chk_en = 1;
    rst = 0;
    @(negedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_addr", mem_req_addr, 0);
    chk("rst_issue", mem_req_valid, 0);
    step();

    // Strobe held high in IDLE must produce nothing.
    b0 = r0_beats + r1_beats;
    mem_resp_valid = 1; mem_resp_data = 32'h5555;
    repeat (10) step();
    mem_resp_valid = 0;
    chk("idle_strobe_beats", r0_beats + r1_beats - b0, 0);

    // r0 burst read from 0x40.
    dq.delete(); b0 = r0_beats; b1 = r1_beats; n = issues;
    do_txn(0, 32'h40, 32'h0, 4'h0, -1);
    chk("rd_issues", issues - n, 1);
    chk("rd_addr", iss_addr, 32'h40);
    chk("rd_mask", iss_mask, 0);
    chk("rd_beats", r0_beats - b0, 16);
    chk("rd_last_on_16", last_beat_no - b0, 16);
    chk("rd_r1_quiet", r1_beats - b1, 0);
    chk("rd_data0", dq[0], 32'hA000);
    chk("rd_data15", dq[15], 32'hA00F);
    step(); step();

    // r1 single-beat write.
    b1 = r1_beats; n = r1_lasts;
    do_txn(1, 32'h80, 32'hDEADBEEF, 4'hF, -1);
    chk("wr_addr", iss_addr, 32'h80);
    chk("wr_data", iss_data, 32'hDEADBEEF);
    chk("wr_mask", iss_mask, 4'hF);
    chk("wr_beats", r1_beats - b1, 1);
    chk("wr_lasts", r1_lasts - n, 1);
    step();
    chk("wr_idle", busy, 0);

    // Burst with a 3-cycle hole between beats 5 and 6.
    b0 = r0_beats;
    do_txn(0, 32'h100, 32'h0, 4'h0, 5);
    chk("gap_beats", r0_beats - b0, 16);
    chk("gap_last_on_16", last_beat_no - b0, 16);
    step();

    // Reset at beat 7 of an r0 burst; prio is 1 at this point.
    b0 = r0_beats;
    r0_req_valid = 1; r0_req_addr = 32'h200; r0_req_mask = 0; mem_resp_valid = 1;
    for (k = 0; k < 50 && (r0_beats - b0) < 7; k++) step();
    rst = 1; step(); rst = 0; r0_req_valid = 0;
    @(negedge clk); #1;
    chk("rst7_busy", busy, 0);
    chk("rst7_resp", {r0_resp_valid, r1_resp_valid, r0_resp_last, r1_resp_last}, 0);
    chk("rst7_addr", mem_req_addr, 0);
    step();
    mem_resp_valid = 0;

    // Both requesting continuously: r0 first (prio reset), then alternate.
    order.delete();
    r0_req_valid = 1; r0_req_addr = 32'h300; r0_req_mask = 4'h3; r0_req_data = 32'h1;
    r1_req_valid = 1; r1_req_addr = 32'h400; r1_req_mask = 4'h0;
    mem_resp_valid = 1;
    for (k = 0; k < 300 && order.size() < 4; k++) step();
    r0_req_valid = 0; r1_req_valid = 0; mem_resp_valid = 0;
    chk("alt_count", order.size(), 4);
    if (order.size() >= 4) begin
      chk("alt0", order[0], 0); chk("alt1", order[1], 1);
      chk("alt2", order[2], 0); chk("alt3", order[3], 1);
    end
    step(); step();

    // r1 read after all that still delivers 16 beats.
    b1 = r1_beats;
    do_txn(1, 32'h500, 32'h0, 4'h0, -1);
    chk("r1_rd_beats", r1_beats - b1, 16);
    step();

    // Random phase: requesters hold until their own last beat.
    s0 = r0_lasts; s1 = r1_lasts;
    for (int c = 0; c < 4000; c++) begin
      done0 = (r0_lasts != s0); done1 = (r1_lasts != s1);
      s0 = r0_lasts; s1 = r1_lasts;
      rst = ($urandom_range(0, 299) == 0);
      if (rst || done0) r0_req_valid = 0;
      else if (!r0_req_valid && $urandom_range(0, 9) < 3) begin
        r0_req_valid = 1; r0_req_addr = $urandom; r0_req_data = $urandom;
        r0_req_mask = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      if (rst || done1) r1_req_valid = 0;
      else if (!r1_req_valid && $urandom_range(0, 9) < 3) begin
        r1_req_valid = 1; r1_req_addr = $urandom; r1_req_data = $urandom;
        r1_req_mask = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      mem_resp_valid = ($urandom_range(0, 9) < 7);
      mem_resp_data = $urandom;
      step();
    end
    rst = 0;
    idle_inputs();
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single external memory port between the instruction-side and data-side `cache` instances. It grants one requester at a time, using round-robin priority. It forwards the granted request to memory as a one-cycle issue. It then routes every response beat back to the owner until the transaction completes: one beat for a write, `BURST_LEN` beats for a line fill. It sits between the caches' `m_req_*`/`m_resp_*` ports and the memory model or controller.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `BURST_LEN`, 16, read beats per line fill (≥2)

Ports (clock and reset first):
- `clk`  in  1  the single clock; all logic is on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `r0_req_valid`  in  1  requester 0 request, held until its last response beat
- `r0_req_addr`  in  `ADDR_W`  requester 0 address
- `r0_req_data`  in  `DATA_W`  requester 0 write data
- `r0_req_mask`  in  4  byte mask; nonzero means write, zero means burst read
- `r0_resp_valid`  out  1  response beat for requester 0
- `r0_resp_last`  out  1  final beat of requester 0 transaction
- `r1_req_valid`, `r1_req_addr`, `r1_req_data`, `r1_req_mask`, `r1_resp_valid`, `r1_resp_last`: same as the r0 ports, for requester 1
- `resp_data`  out  `DATA_W`  response data, shared by both requesters
- `mem_req_valid`  out  1  one-cycle issue pulse to memory
- `mem_req_addr`  out  `ADDR_W`  registered address of the granted requester
- `mem_req_data`  out  `DATA_W`  registered write data
- `mem_req_mask`  out  4  registered mask
- `mem_resp_valid`  in  1  memory beat strobe
- `mem_resp_data`  in  `DATA_W`  memory beat data
- `busy`  out  1  high in ISSUE and WAIT

## Operation
- States: IDLE, ISSUE, WAIT. Registers:
  - `owner` (1 bit)
  - `prio` (1 bit; the requester favoured on a tie)
  - `is_wr`
  - beat counter `cnt`, width $clog2(BURST_LEN)
- IDLE, when any `rX_req_valid` is high:
  - Grant requester: the only one requesting, or `prio` if both are requesting.
  - Latch its addr, data and mask into `mem_req_*`.
  - Set `is_wr = |mask` and `cnt = 0`, then go to ISSUE.
- IDLE with no request: stay in IDLE. `mem_req_*` hold their last values.
- ISSUE: `mem_req_valid = 1` for exactly this cycle, then go to WAIT.
- WAIT, on each `mem_resp_valid`:
  - Drive `r<owner>_resp_valid = 1` and increment `cnt`.
  - Last beat: `is_wr`, or `cnt == BURST_LEN-1` for a read. On the last beat, assert `r<owner>_resp_last` and go to IDLE. Set `prio = ~owner`.
- Requester valid is sampled only in IDLE. A requester that drops `req_valid` mid-transaction does not abort it; the remaining beats are still counted and forwarded.
- `mem_resp_valid` in IDLE or ISSUE is ignored. It produces no `resp_valid` and no count, because the memory model may hold the strobe high while idle.
- `resp_data = mem_resp_data` at all times, combinationally. Requesters qualify it with their own `resp_valid`.
- The non-owner's `resp_valid` and `resp_last` are always 0.
- Addresses pass through unchanged. Burst address increment is done by memory.

## Timing
- Reset values:
  - State IDLE, `prio = 0`, `owner = 0`, `cnt = 0`, `is_wr = 0`.
  - `mem_req_valid = 0`, `mem_req_addr/data/mask = 0`, `busy = 0`.
  - All `resp_valid` and `resp_last` = 0.
- Reset mid-transaction: the next cycle is IDLE with reset values. Beats still in flight from memory are dropped (ignored in IDLE).
- Request sampled in IDLE at edge N: `mem_req_valid` is high during cycle N+1, and WAIT starts at N+2.
- Response routing: `rX_resp_valid`, `rX_resp_last` and `resp_data` are combinational from `mem_resp_valid` and `mem_resp_data` in WAIT, with zero added latency.
- After the last beat at edge M, the state is IDLE in cycle M+1. The next issue pulse can be in cycle M+2 at the earliest, so there is a minimum 2-cycle gap between transactions.
- Memory can insert any number of idle cycles between beats; `cnt` advances only on the strobe.
- `cnt` never wraps within a transaction; it is cleared on each grant.

## Test plan
- r0 read addr 0x40, mask 0: one `mem_req_valid` pulse with addr 0x40, mask 0. Exactly 16 `r0_resp_valid` beats whose `resp_data` equals mem[0..15]. `r0_resp_last` only on beat 16. r1 outputs stay 0.
- r1 write addr 0x80, data 0xDEADBEEF, mask 0xF: issue carries those values. The single memory beat gives `r1_resp_valid = r1_resp_last = 1`, then IDLE.
- Both requesting continuously from reset: grants go r0, r1, r0, r1. Each transaction completes fully before the next issue, with no overlapping `busy` gaps shorter than 2 cycles.
- `mem_resp_valid` held high for 10 cycles in IDLE: no `resp_valid` on either requester, and `cnt` stays 0. A subsequent read still delivers exactly 16 beats.
- Memory inserts 3 idle cycles between beats 5 and 6 of a burst: beat count is unaffected, and last is asserted on the 16th strobe.
- `rst` pulsed at beat 7 of an r0 burst: all outputs are 0 the next cycle. A new r1 read issues cleanly and gets 16 beats counted from zero. `prio` is back to 0.
